// File: rtl/udma_smi_pkg.sv
// Shared types and constants for the udma SMI/MDIO (Clause 22) master engine.
package udma_smi_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_PRE,
    S_ST,
    S_OP,
    S_PHY,
    S_REG,
    S_TA,
    S_DATA,
    S_DONE
  } smi_state_e;

  localparam logic [1:0] SMI_ST    = 2'b01;
  localparam logic [1:0] SMI_OP_RD = 2'b10;
  localparam logic [1:0] SMI_OP_WR = 2'b01;

  localparam int SMI_PRE_LEN = 32;
  localparam int SMI_DATA_W  = 16;
  localparam int SMI_ADDR_W  = 5;

  // Bit counter reload value on entry to a frame field (field length minus one).
  function automatic logic [4:0] smi_bit_len(smi_state_e s);
    case (s)
      S_PRE:        smi_bit_len = 5'(SMI_PRE_LEN - 1);
      S_ST, S_OP,
      S_TA:         smi_bit_len = 5'd1;
      S_PHY, S_REG: smi_bit_len = 5'(SMI_ADDR_W - 1);
      S_DATA:       smi_bit_len = 5'(SMI_DATA_W - 1);
      default:      smi_bit_len = 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/udma_smi_master_if.sv
// Register-block side control/status bundle of the SMI master engine.
interface udma_smi_master_if;
  import udma_smi_pkg::*;

  logic                  start_i;
  logic                  rw_i;
  logic [SMI_ADDR_W-1:0] phy_addr_i;
  logic [SMI_ADDR_W-1:0] reg_addr_i;
  logic [SMI_DATA_W-1:0] wr_data_i;
  logic                  busy_o;
  logic                  nd_o;
  logic [SMI_DATA_W-1:0] rd_data_o;

  // The register block issues commands; the engine is the responder.
  modport master (
    output start_i, rw_i, phy_addr_i, reg_addr_i, wr_data_i,
    input  busy_o, nd_o, rd_data_o
  );

  modport slave (
    input  start_i, rw_i, phy_addr_i, reg_addr_i, wr_data_i,
    output busy_o, nd_o, rd_data_o
  );

endinterface

// File: rtl/udma_smi_clkgen.sv
// MDC generator: CLK_DIV clk_i cycles per half-period, held low/reset while disabled,
// with one-cycle rise/fall strobes aligned to the clk_i edge on which MDC changes.
module udma_smi_clkgen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic en,
  output logic smi_mdc_o,
  output logic mdc_rise,
  output logic mdc_fall
);

  logic [7:0] div_cnt_q;
  logic       mdc_q;
  logic       half_done;

  assign half_done = en && (div_cnt_q == 8'(CLK_DIV - 1));
  assign mdc_rise  = half_done && !mdc_q;
  assign mdc_fall  = half_done && mdc_q;
  assign smi_mdc_o = mdc_q;

  // Holding the divider at zero while disabled makes the first rise exactly CLK_DIV cycles after enable.
  always_ff @(posedge clk_i) begin
    if (!rstn_i || !en) begin
      div_cnt_q <= 8'd0;
      mdc_q     <= 1'b0;
    end else if (half_done) begin
      div_cnt_q <= 8'd0;
      mdc_q     <= ~mdc_q;
    end else begin
      div_cnt_q <= div_cnt_q + 8'd1;
    end
  end

endmodule

// File: rtl/udma_smi_master.sv
// SMI/MDIO Clause 22 master: serializes one management frame per start_i rising edge.
// Optional build macro SMI_PREAMBLE_SUPPRESS_EN adds preamble_skip_i to omit the 32-bit preamble.
module udma_smi_master
  import udma_smi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  udma_smi_master_if.slave    ctrl,
`ifdef SMI_PREAMBLE_SUPPRESS_EN
  input  logic                preamble_skip_i,
`endif
  output logic                smi_mdc_o,
  output logic                smi_mdio_o,
  output logic                smi_mdio_oe_o,
  input  logic                smi_mdio_i
);

  smi_state_e            state_q, state_d;
  logic [4:0]            bit_cnt_q, bit_cnt_d;
  logic                  start_q;
  logic                  start_acc;
  logic                  skip_pre;
  logic                  busy;
  logic                  mdc_rise, mdc_fall;
  logic                  rw_q;
  logic [SMI_ADDR_W-1:0] phy_q, reg_q;
  logic [SMI_DATA_W-1:0] wr_q, rd_shift_q, rd_data_q;
  logic [1:0]            op_code;

`ifdef SMI_PREAMBLE_SUPPRESS_EN
  assign skip_pre = preamble_skip_i;
`else
  assign skip_pre = 1'b0;
`endif

  assign start_acc = (state_q == S_IDLE) && ctrl.start_i && !start_q;
  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign op_code   = rw_q ? SMI_OP_WR : SMI_OP_RD;

  assign ctrl.busy_o    = busy;
  assign ctrl.nd_o      = (state_q == S_DONE);
  assign ctrl.rd_data_o = rd_data_q;

  udma_smi_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .en        (busy),
    .smi_mdc_o (smi_mdc_o),
    .mdc_rise  (mdc_rise),
    .mdc_fall  (mdc_fall)
  );

  // Fields advance only on an MDC falling edge, so every new bit starts with MDC low.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      S_IDLE: if (start_acc) state_d = skip_pre ? S_ST : S_PRE;
      S_DONE: state_d = S_IDLE;
      default: begin
        if (mdc_fall) begin
          if (bit_cnt_q != 5'd0) begin
            bit_cnt_d = bit_cnt_q - 5'd1;
          end else begin
            case (state_q)
              S_PRE:   state_d = S_ST;
              S_ST:    state_d = S_OP;
              S_OP:    state_d = S_PHY;
              S_PHY:   state_d = S_REG;
              S_REG:   state_d = S_TA;
              S_TA:    state_d = S_DATA;
              default: state_d = S_DONE;
            endcase
          end
        end
      end
    endcase
    if (state_d != state_q) bit_cnt_d = smi_bit_len(state_d);
  end

  // Reads release MDIO from turnaround onward so the PHY can drive it.
  always_comb begin
    smi_mdio_o    = 1'b1;
    smi_mdio_oe_o = 1'b0;
    case (state_q)
      S_PRE: smi_mdio_oe_o = 1'b1;
      S_ST: begin
        smi_mdio_oe_o = 1'b1;
        smi_mdio_o    = SMI_ST[bit_cnt_q[0]];
      end
      S_OP: begin
        smi_mdio_oe_o = 1'b1;
        smi_mdio_o    = op_code[bit_cnt_q[0]];
      end
      S_PHY: begin
        smi_mdio_oe_o = 1'b1;
        smi_mdio_o    = phy_q[bit_cnt_q[2:0]];
      end
      S_REG: begin
        smi_mdio_oe_o = 1'b1;
        smi_mdio_o    = reg_q[bit_cnt_q[2:0]];
      end
      S_TA: begin
        smi_mdio_oe_o = rw_q;
        smi_mdio_o    = rw_q ? bit_cnt_q[0] : 1'b1;
      end
      S_DATA: begin
        smi_mdio_oe_o = rw_q;
        smi_mdio_o    = rw_q ? wr_q[bit_cnt_q[3:0]] : 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= 5'd0;
      start_q    <= 1'b0;
      rw_q       <= 1'b0;
      phy_q      <= '0;
      reg_q      <= '0;
      wr_q       <= '0;
      rd_shift_q <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      start_q   <= ctrl.start_i;
      if (start_acc) begin
        rw_q  <= ctrl.rw_i;
        phy_q <= ctrl.phy_addr_i;
        reg_q <= ctrl.reg_addr_i;
        wr_q  <= ctrl.wr_data_i;
      end
      if ((state_q == S_DATA) && !rw_q && mdc_rise)
        rd_shift_q <= {rd_shift_q[SMI_DATA_W-2:0], smi_mdio_i};
      // Loading on the final fall makes the new word visible in the nd_o cycle.
      if ((state_q == S_DATA) && (state_d == S_DONE) && !rw_q)
        rd_data_q <= rd_shift_q;
    end
  end

endmodule

// File: tb/tb_udma_smi_master.sv
// Scoreboard bench for udma_smi_master: instance 0 at CLK_DIV=4, instance 1 at CLK_DIV=1,
// with a PHY model answering reads and a monitor checking each completed frame.
module tb_udma_smi_master;

  typedef struct {
    int          inst;
    logic [31:0] lo;
    logic [31:0] mask;
    logic        skip;
    int          nbits;
    int          busy;
    logic [15:0] rd;
  } exp_t;

  logic clk = 1'b0;
  logic rstn;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  logic        start_a[2];
  logic        rw_a[2];
  logic [4:0]  phy_a[2];
  logic [4:0]  reg_a[2];
  logic [15:0] wd_a[2];
  logic        skip_a[2];
  logic        busy_a[2];
  logic        nd_a[2];
  logic [15:0] rd_a[2];
  logic        mdc_a[2];
  logic        mdio_a[2];
  logic        oe_a[2];
  logic        mdio_in[2];

  logic        cur_rw[2];
  logic        cur_skip[2];
  logic [15:0] phy_word[2];
  int          rise_cnt[2];
  int          busy_cnt[2];
  int          nd_total[2];
  logic [63:0] cap_bits[2];
  logic [63:0] cap_oe[2];
  logic        mdc_prev[2];
  logic        nd_prev[2];

  always #5 clk = ~clk;

  udma_smi_master_if ctrl_if0 ();
  udma_smi_master_if ctrl_if1 ();

  assign ctrl_if0.start_i    = start_a[0];
  assign ctrl_if0.rw_i       = rw_a[0];
  assign ctrl_if0.phy_addr_i = phy_a[0];
  assign ctrl_if0.reg_addr_i = reg_a[0];
  assign ctrl_if0.wr_data_i  = wd_a[0];
  assign busy_a[0]           = ctrl_if0.busy_o;
  assign nd_a[0]             = ctrl_if0.nd_o;
  assign rd_a[0]             = ctrl_if0.rd_data_o;

  assign ctrl_if1.start_i    = start_a[1];
  assign ctrl_if1.rw_i       = rw_a[1];
  assign ctrl_if1.phy_addr_i = phy_a[1];
  assign ctrl_if1.reg_addr_i = reg_a[1];
  assign ctrl_if1.wr_data_i  = wd_a[1];
  assign busy_a[1]           = ctrl_if1.busy_o;
  assign nd_a[1]             = ctrl_if1.nd_o;
  assign rd_a[1]             = ctrl_if1.rd_data_o;

  udma_smi_master #(.CLK_DIV(4)) dut0 (
    .clk_i           (clk),
    .rstn_i          (rstn),
    .ctrl            (ctrl_if0),
`ifdef SMI_PREAMBLE_SUPPRESS_EN
    .preamble_skip_i (skip_a[0]),
`endif
    .smi_mdc_o       (mdc_a[0]),
    .smi_mdio_o      (mdio_a[0]),
    .smi_mdio_oe_o   (oe_a[0]),
    .smi_mdio_i      (mdio_in[0])
  );

  udma_smi_master #(.CLK_DIV(1)) dut1 (
    .clk_i           (clk),
    .rstn_i          (rstn),
    .ctrl            (ctrl_if1),
`ifdef SMI_PREAMBLE_SUPPRESS_EN
    .preamble_skip_i (skip_a[1]),
`endif
    .smi_mdc_o       (mdc_a[1]),
    .smi_mdio_o      (mdio_a[1]),
    .smi_mdio_oe_o   (oe_a[1]),
    .smi_mdio_i      (mdio_in[1])
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic rw, input logic [4:0] phy,
                               input logic [4:0] reg_addr, input logic [15:0] wdata,
                               input logic [15:0] phy_rd, input logic skip, input logic hold,
                               input logic [31:0] lo, input logic [31:0] mask,
                               input int busy, input logic [15:0] rd);
    exp_t e;
    @(negedge clk);
    rw_a[idx]     = rw;
    phy_a[idx]    = phy;
    reg_a[idx]    = reg_addr;
    wd_a[idx]     = wdata;
    skip_a[idx]   = skip;
    cur_rw[idx]   = rw;
    cur_skip[idx] = skip;
    phy_word[idx] = phy_rd;
    e.inst  = idx;
    e.lo    = lo;
    e.mask  = mask;
    e.skip  = skip;
    e.nbits = skip ? 32 : 64;
    e.busy  = busy;
    e.rd    = rd;
    exp_q.push_back(e);
    start_a[idx] = 1'b1;
    @(negedge clk);
    if (!hold) start_a[idx] = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL frame_timeout actual=pending expected=done");
      exp_q.delete();
    end
  endtask

  // Monitor and PHY model: capture bits on MDC rise, score the frame at nd_o, present read data.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (!rstn) begin
        rise_cnt[g] = 0;
        busy_cnt[g] = 0;
        cap_bits[g] = '0;
        cap_oe[g]   = '0;
        mdc_prev[g] = 1'b0;
        nd_prev[g]  = 1'b0;
        mdio_in[g]  = 1'b1;
      end else begin
        if (mdc_a[g] && !mdc_prev[g]) begin
          cap_bits[g] = {cap_bits[g][62:0], mdio_a[g]};
          cap_oe[g]   = {cap_oe[g][62:0], oe_a[g]};
          rise_cnt[g]++;
        end
        mdc_prev[g] = mdc_a[g];
        if (busy_a[g]) busy_cnt[g]++;
        if (nd_a[g]) begin
          nd_total[g]++;
          checkOutput("nd_single_cycle", 64'(nd_prev[g]), 64'd0);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_nd inst=%0d actual=1 expected=0", g);
          end else begin
            mon_e = exp_q.pop_front();
            checkOutput("nd_instance", 64'(g), 64'(mon_e.inst));
            if (!mon_e.skip) begin
              checkOutput("preamble_bits", 64'(cap_bits[g][63:32]), 64'hFFFF_FFFF);
              checkOutput("preamble_oe", 64'(cap_oe[g][63:32]), 64'hFFFF_FFFF);
            end
            checkOutput("frame_bits", 64'(cap_bits[g][31:0] & mon_e.mask), 64'(mon_e.lo));
            checkOutput("frame_oe", 64'(cap_oe[g][31:0]), 64'(mon_e.mask));
            checkOutput("mdc_periods", 64'(rise_cnt[g]), 64'(mon_e.nbits));
            checkOutput("busy_cycles", 64'(busy_cnt[g]), 64'(mon_e.busy));
            checkOutput("busy_at_nd", 64'(busy_a[g]), 64'd0);
            checkOutput("rd_data", 64'(rd_a[g]), 64'(mon_e.rd));
          end
          rise_cnt[g] = 0;
          busy_cnt[g] = 0;
          cap_bits[g] = '0;
          cap_oe[g]   = '0;
        end
        nd_prev[g] = nd_a[g];
        begin
          int k;
          int ds;
          k  = rise_cnt[g];
          ds = cur_skip[g] ? 16 : 48;
          if (!cur_rw[g] && (k >= ds) && (k < ds + 16))
            mdio_in[g] = phy_word[g][15 - (k - ds)];
          else
            mdio_in[g] = 1'b1;
        end
      end
    end
  end

  initial begin
    int base;
    for (int i = 0; i < 2; i++) begin
      start_a[i] = 1'b0; rw_a[i] = 1'b0; phy_a[i] = '0; reg_a[i] = '0;
      wd_a[i] = '0; skip_a[i] = 1'b0; cur_rw[i] = 1'b1; cur_skip[i] = 1'b0;
      phy_word[i] = '0; nd_total[i] = 0;
    end
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 64'(busy_a[0]), 64'd0);
    checkOutput("reset_nd", 64'(nd_a[0]), 64'd0);
    checkOutput("reset_rd_data", 64'(rd_a[0]), 64'd0);
    checkOutput("reset_mdc", 64'(mdc_a[0]), 64'd0);
    checkOutput("reset_mdio", 64'(mdio_a[0]), 64'd1);
    checkOutput("reset_oe", 64'(oe_a[0]), 64'd0);
    checkOutput("reset_mdc_div1", 64'(mdc_a[1]), 64'd0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] write phy=01 reg=00 data=1140");
    applyStimulus(0, 1'b1, 5'h01, 5'h00, 16'h1140, 16'h0000, 1'b0, 1'b0,
                  32'h5082_1140, 32'hFFFF_FFFF, 512, 16'h0000);
    waitDone(2000);

    $display("[TB] read phy=03 reg=02, PHY returns 0141");
    applyStimulus(0, 1'b0, 5'h03, 5'h02, 16'h0000, 16'h0141, 1'b0, 1'b0,
                  32'h6188_0000, 32'hFFFC_0000, 512, 16'h0141);
    waitDone(2000);

    $display("[TB] restart edge mid-frame and start held high");
    base = nd_total[0];
    applyStimulus(0, 1'b1, 5'h1A, 5'h05, 16'hA5A5, 16'h0000, 1'b0, 1'b1,
                  32'h5D16_A5A5, 32'hFFFF_FFFF, 512, 16'h0141);
    repeat (100) @(negedge clk);
    start_a[0] = 1'b0;
    repeat (2) @(negedge clk);
    start_a[0] = 1'b1;
    waitDone(2000);
    repeat (600) @(negedge clk);
    checkOutput("single_frame", 64'(nd_total[0] - base), 64'd1);
    checkOutput("idle_while_held", 64'(busy_a[0]), 64'd0);
    start_a[0] = 1'b0;

    $display("[TB] reset during PHYAD bits");
    @(negedge clk);
    rw_a[0] = 1'b1; phy_a[0] = 5'h15; reg_a[0] = 5'h03; wd_a[0] = 16'h1234;
    cur_rw[0] = 1'b1;
    start_a[0] = 1'b1;
    @(negedge clk);
    start_a[0] = 1'b0;
    base = nd_total[0];
    repeat (298) @(negedge clk);
    checkOutput("abort_busy_before", 64'(busy_a[0]), 64'd1);
    rstn = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy", 64'(busy_a[0]), 64'd0);
    checkOutput("abort_nd", 64'(nd_a[0]), 64'd0);
    checkOutput("abort_rd_data", 64'(rd_a[0]), 64'd0);
    checkOutput("abort_mdc", 64'(mdc_a[0]), 64'd0);
    checkOutput("abort_mdio", 64'(mdio_a[0]), 64'd1);
    checkOutput("abort_oe", 64'(oe_a[0]), 64'd0);
    rstn = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("abort_no_nd", 64'(nd_total[0] - base), 64'd0);
    applyStimulus(0, 1'b1, 5'h00, 5'h1F, 16'h0000, 16'h0000, 1'b0, 1'b0,
                  32'h507E_0000, 32'hFFFF_FFFF, 512, 16'h0000);
    waitDone(2000);

    $display("[TB] CLK_DIV=1 write data=FFFF");
    applyStimulus(1, 1'b1, 5'h1F, 5'h1F, 16'hFFFF, 16'h0000, 1'b0, 1'b0,
                  32'h5FFE_FFFF, 32'hFFFF_FFFF, 128, 16'h0000);
    waitDone(1000);

`ifdef SMI_PREAMBLE_SUPPRESS_EN
    $display("[TB] preamble suppressed write");
    applyStimulus(0, 1'b1, 5'h01, 5'h00, 16'h1140, 16'h0000, 1'b1, 1'b0,
                  32'h5082_1140, 32'hFFFF_FFFF, 256, 16'h0000);
    waitDone(2000);
    skip_a[0] = 1'b0;
    cur_skip[0] = 1'b0;
`endif

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
